// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle 8x8 multiplier between N_REQ requesters.
// Captures the winner's operands at grant and returns the product with a one-cycle done pulse.
module mul_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [8*N_REQ-1:0]   a_bi,
  input  logic [8*N_REQ-1:0]   b_bi,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     done_o,
  output logic [15:0]          y_bo,
  output logic                 busy_o,
  output logic [7:0]           mul_a_bo,
  output logic [7:0]           mul_b_bo,
  output logic                 mul_start_o,
  input  logic                 mul_busy_i,
  input  logic [15:0]          mul_y_bi
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    DONE     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [PROD_W-1:0]   y_q, y_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic                start_q, start_d;

  logic [PTR_W-1:0]    win_c;
  logic                found_c;
  int unsigned         dist_c;
  int unsigned         best_c;
  logic [N_REQ-1:0]    gnt_sel_c;
  logic [DATA_W-1:0]   a_sel_c;
  logic [DATA_W-1:0]   b_sel_c;

  // Winner = requester at the smallest rotated distance from ptr+1.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    dist_c  = 0;
    best_c  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      dist_c = k + N_REQ - 1 - 32'(ptr_q);
      if (dist_c >= N_REQ) dist_c = dist_c - N_REQ;
      if (req_i[k] && (!found_c || dist_c < best_c)) begin
        found_c = 1'b1;
        best_c  = dist_c;
        win_c   = PTR_W'(k);
      end
    end
  end

  // One-hot grant and operand mux for the winner.
  always_comb begin
    gnt_sel_c = '0;
    a_sel_c   = '0;
    b_sel_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_c == PTR_W'(k)) begin
        gnt_sel_c[k] = 1'b1;
        a_sel_c      = a_bi[DATA_W*k +: DATA_W];
        b_sel_c      = b_bi[DATA_W*k +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    y_d     = y_q;
    busy_d  = busy_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d   = gnt_sel_c;
          win_d   = win_c;
          mul_a_d = a_sel_c;
          mul_b_d = b_sel_c;
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = WAIT_MUL;
        end
      end
      WAIT_MUL: begin
        // The start cycle itself never completes: mul has not raised busy yet.
        if (!mul_busy_i && !start_q) begin
          y_d     = mul_y_bi;
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = win_q;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      start_q <= start_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign y_bo        = y_q;
  assign busy_o      = busy_q;
  assign mul_a_bo    = mul_a_q;
  assign mul_b_bo    = mul_b_q;
  assign mul_start_o = start_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural multi-cycle mul plus a scoreboard of expected completions.
module tb_mul_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_bi;
  logic [31:0] b_bi;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] y;
  logic        busy;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic        mul_busy;
  logic [15:0] mul_y;

  logic [15:0] mul_prod;
  int          mul_cnt;
  int          mul_lat;

  int checks;
  int errors;

  logic [3:0]  exp_done_q[$];
  logic [15:0] exp_y_q[$];

  mul_arbiter #(.N_REQ(4), .PTR_W(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .a_bi       (a_bi),
    .b_bi       (b_bi),
    .gnt_o      (gnt),
    .done_o     (done),
    .y_bo       (y),
    .busy_o     (busy),
    .mul_a_bo   (mul_a),
    .mul_b_bo   (mul_b),
    .mul_start_o(mul_start),
    .mul_busy_i (mul_busy),
    .mul_y_bi   (mul_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: busy for mul_lat cycles after start; output is garbage while busy.
  always @(posedge clk) begin
    if (rst) begin
      mul_busy <= 1'b0;
      mul_cnt  <= 0;
      mul_prod <= 16'h0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      mul_cnt  <= mul_lat;
      mul_prod <= 16'(mul_a) * 16'(mul_b);
    end else if (mul_cnt > 1) begin
      mul_cnt <= mul_cnt - 1;
    end else if (mul_cnt == 1) begin
      mul_cnt  <= 0;
      mul_busy <= 1'b0;
    end
  end
  assign mul_y = mul_busy ? ~mul_prod : mul_prod;

  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    a_bi[8*k +: 8] = a;
    b_bi[8*k +: 8] = b;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [15:0] p);
    exp_done_q.push_back(d);
    exp_y_q.push_back(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for the next done pulse and check it against the scoreboard head.
  task automatic collect(output int cyc);
    logic        found;
    logic [3:0]  ed;
    logic [15:0] ey;
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done !== 4'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL collect_timeout: no done_o within %0d cycles", cyc);
    end else if (exp_done_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: done_o=%b y_bo=%0d with empty scoreboard", done, y);
    end else begin
      ed = exp_done_q.pop_front();
      ey = exp_y_q.pop_front();
      checks++;
      if (done !== ed) begin
        errors++;
        $display("FAIL done_onehot: got %b expected %b", done, ed);
      end
      if (y !== ey) begin
        errors++;
        $display("FAIL product: got %0d expected %0d", y, ey);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, done, y, busy, mul_start, mul_a, mul_b} !== 43'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b y=%0d busy=%b start=%b a=%0d b=%0d expected all 0",
               gnt, done, y, busy, mul_start, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    int cyc;
    do_reset();
    mul_lat = 3;
    set_ops(0, 8'd3, 8'd5);
    push_exp(4'b0001, 16'd15);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    checks++;
    if (mul_start !== 1'b1 || mul_a !== 8'd3 || mul_b !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: start=%b a=%0d b=%0d busy=%b expected 1 3 5 1", mul_start, mul_a, mul_b, busy);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: start=%b expected 0", mul_start); end
    collect(cyc);
    checks++;
    if (cyc != mul_lat + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cyc, mul_lat + 1); end
    req = 4'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL single_after_done: busy=%b done=%b expected 0 0000", busy, done);
    end
  endtask

  task automatic test_rotate();
    int cyc;
    do_reset();
    mul_lat = 2;
    for (int k = 0; k < 4; k++) set_ops(k, 8'(k + 1), 8'd10);
    push_exp(4'b0001, 16'd10);
    push_exp(4'b0010, 16'd20);
    push_exp(4'b0100, 16'd30);
    push_exp(4'b1000, 16'd40);
    push_exp(4'b0001, 16'd10);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) collect(cyc);
    req = 4'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rotate_idle: gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
  endtask

  task automatic test_max();
    int cyc;
    mul_lat = 3;
    set_ops(2, 8'd255, 8'd255);
    push_exp(4'b0100, 16'd65025);
    req = 4'b0100;
    collect(cyc);
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_capture();
    int cyc;
    mul_lat = 4;
    set_ops(1, 8'd7, 8'd9);
    push_exp(4'b0010, 16'd63);
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL capture_gnt: got %b expected 0010", gnt); end
    @(negedge clk);
    set_ops(1, 8'd200, 8'd200);
    req = 4'b0;
    collect(cyc);
    repeat (4) @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL capture_no_regrant: gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    logic seen;
    mul_lat = 5;
    set_ops(0, 8'd6, 8'd7);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_gnt: got %b expected 0001", gnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({gnt, done, y, busy, mul_start, mul_a, mul_b} !== 43'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: gnt=%b done=%b y=%0d busy=%b start=%b a=%0d b=%0d expected all 0",
               gnt, done, y, busy, mul_start, mul_a, mul_b);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 4'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_stale_done: got done pulse expected none"); end
    set_ops(3, 8'd11, 8'd13);
    push_exp(4'b1000, 16'd143);
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_regrant: got %b expected 1000", gnt); end
    collect(cyc);
    req = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    mul_lat = 1;
    set_ops(1, 8'd2, 8'd3);
    set_ops(0, 8'd4, 8'd5);
    push_exp(4'b0010, 16'd6);
    req = 4'b0010;
    collect(cyc);
    req = 4'b0;
    @(negedge clk);
    push_exp(4'b0001, 16'd20);
    push_exp(4'b0010, 16'd6);
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b expected 0001", gnt); end
    collect(cyc);
    collect(cyc);
    req = 4'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    req     = 4'b0;
    a_bi    = 32'h0;
    b_bi    = 32'h0;
    mul_lat = 3;
    test_reset();
    test_single();
    test_rotate();
    test_max();
    test_capture();
    test_reset_mid();
    test_wrap();
    checks++;
    if (exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected completions never seen", exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one instance of the team's multi-cycle 8x8 unsigned `mul` unit between N_REQ independent requesters.
- Uses round-robin arbitration. Sequences the mul start/busy handshake and returns the 16-bit product to the granted requester with a one-cycle done pulse.
- Sits between compute controllers (cube-root/multiply sequencers, filters) and a single shared multiplier, replacing per-controller mul instances.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- PTR_W, 2, width of round-robin pointer; must be >= clog2(N_REQ).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester request level; held high until that requester's done_o pulse.
- a_bi  in  8*N_REQ  operand A, requester k at bits [8k+7:8k]; sampled at grant.
- b_bi  in  8*N_REQ  operand B, same packing; sampled at grant.
- gnt_o  out  N_REQ  one-hot grant, high for the whole service of the granted requester.
- done_o  out  N_REQ  one-hot, one-cycle pulse marking y_bo valid for that requester.
- y_bo  out  16  product of the last completed operation; holds until the next completion.
- busy_o  out  1  high whenever the state is not IDLE.
- mul_a_bo  out  8  operand A to mul.
- mul_b_bo  out  8  operand B to mul.
- mul_start_o  out  1  one-cycle start pulse to mul.
- mul_busy_i  in  1  mul busy; mul raises it the cycle after start and drops it when the result is valid.
- mul_y_bi  in  16  mul result; valid when mul_busy_i is low after a start.

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - gnt_o = 0, done_o = 0, y_bo = 0, busy_o = 0.
  - mul_start_o = 0, mul_a_bo = 0, mul_b_bo = 0.
  - state = IDLE; last-grant pointer = N_REQ-1, so requester 0 has top priority after reset.
- States: IDLE, WAIT_MUL, DONE.
- IDLE:
  - If req_i != 0, choose winner w = first set bit scanning from (ptr+1) mod N_REQ upward with wrap.
  - Register gnt_o = onehot(w), mul_a_bo = a_bi[w], mul_b_bo = b_bi[w], mul_start_o = 1, busy_o = 1.
  - Go to WAIT_MUL.
  - If req_i == 0, stay in IDLE with all outputs unchanged except done_o = 0.
- WAIT_MUL:
  - mul_start_o <= 0.
  - Completion condition: mul_busy_i == 0 and mul_start_o == 0 (the first WAIT_MUL cycle never completes).
  - On completion:
    - y_bo <= mul_y_bi; done_o <= gnt_o; gnt_o <= 0; ptr <= w.
    - Go to DONE.
- DONE:
  - done_o <= 0, busy_o <= 0. Go to IDLE.
  - req_i is ignored this cycle, so the requester may drop req on the edge after it sees done_o.
- Latency:
  - A request seen in IDLE at edge E0 drives mul_start_o high after E0.
  - done_o rises (L+2) cycles after E0, where L is the mul busy duration.
  - Back-to-back service has a 1-cycle DONE gap plus 1 IDLE arbitration cycle per operation.
- Operand capture: a_bi/b_bi are captured only at grant. Later changes do not affect the running operation.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,...,N_REQ-1,0,... No requester waits more than N_REQ-1 operations.
- Request dropped while granted: the operation still completes and done_o still pulses (result discarded by the requester). It is not re-granted unless req_i rises again.
- New requests arriving during WAIT_MUL/DONE wait for IDLE. There is no preemption.
- Reset mid-operation: everything returns to its reset value the next edge and no done_o is produced. mul shares rst_i, so no stale completion can be seen later.
- Arithmetic: unsigned 8x8 -> 16. No truncation; the result width equals the mul output.

Test Plan:
- Reset, then req_i=0001, a0=3, b0=5. Required:
  - gnt_o=0001 after 1 edge.
  - One-cycle mul_start_o with mul_a_bo=3, mul_b_bo=5.
  - done_o=0001 with y_bo=15.
  - busy_o low after DONE.
- req_i=1111 held continuously, operands ak=k+1, bk=10. Required:
  - Grant order 0,1,2,3,0.
  - Products 10,20,30,40, each with the matching one-hot done_o.
- Requester 2 with a2=255, b2=255. Required: y_bo=65025, done_o=0100.
- During WAIT_MUL for requester 1, change a1/b1 and drop req_i[1]. Required: product of the originally sampled operands, done_o=0010 still pulses, no further grant to 1.
- Assert rst_i for one cycle while in WAIT_MUL. Required:
  - All outputs 0 next cycle and no done_o.
  - A following req_i=1000 is granted first to requester 3, since ptr reset makes the scan start at 0 and only 3 is requesting.
- Requester 1 completes, then req_i=0011. Required: requester 0 is granted next, showing wrap from ptr=1 scans 2,3,0.
